// File: rtl/neuron_accum.sv
`default_nettype none
// ============================================================================
// Module   : neuron_accum
// Brief    : Streaming multiply-accumulate of one neuron's product terms,
//            followed by an arithmetic shift and saturation to DataWidth.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_accum #(
  parameter int DataWidth = 16,
  parameter int LenWidth  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LenWidth-1:0]         cfg_len,
  input  logic [3:0]                  cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DataWidth-1:0] in_act,
  input  logic signed [DataWidth-1:0] in_wgt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DataWidth-1:0] out_preact,
  output logic                        out_sat,
  output logic                        busy
);

  // Headroom of LenWidth bits keeps the sum of up to 2^LenWidth products exact.
  localparam int AccWidth = 2*DataWidth + LenWidth;

  localparam logic signed [AccWidth-1:0] c_acc_max =
    {{(AccWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] c_acc_min =
    {{(AccWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t                        r_state, w_state_next;
  logic signed [AccWidth-1:0]    r_acc, w_acc_next;
  logic [LenWidth-1:0]           r_cnt, w_cnt_next;
  logic [LenWidth-1:0]           r_len, w_len_next;
  logic [3:0]                    r_shift, w_shift_next;
  logic signed [2*DataWidth-1:0] w_prod;
  logic signed [AccWidth-1:0]    w_prod_ext;
  logic signed [AccWidth-1:0]    w_shifted;
  logic signed [DataWidth-1:0]   w_clamped;
  logic                          w_clamp_sat;
  logic                          w_accept;
  logic                          w_load_out;

  assign in_ready  = (r_state != OUT);
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;

  assign w_prod = $signed({{DataWidth{in_act[DataWidth-1]}}, in_act}) *
                  $signed({{DataWidth{in_wgt[DataWidth-1]}}, in_wgt});
  assign w_prod_ext = {{LenWidth{w_prod[2*DataWidth-1]}}, w_prod};

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_shift_next = r_shift;
    w_load_out   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_next   = w_prod_ext;
          w_cnt_next   = LenWidth'(1);
          w_len_next   = (cfg_len == '0) ? LenWidth'(1) : cfg_len;
          w_shift_next = cfg_shift;
          if (w_len_next == LenWidth'(1)) begin
            w_state_next = OUT;
            w_load_out   = 1'b1;
          end else begin
            w_state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_next = r_acc + w_prod_ext;
          w_cnt_next = r_cnt + LenWidth'(1);
          if (w_cnt_next == r_len) begin
            w_state_next = OUT;
            w_load_out   = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shift/clamp works on the post-update sum so the result registers on OUT entry.
  always_comb begin
    w_shifted   = w_acc_next >>> w_shift_next;
    w_clamped   = w_shifted[DataWidth-1:0];
    w_clamp_sat = 1'b0;
    if (w_shifted > c_acc_max) begin
      w_clamped   = {1'b0, {(DataWidth-1){1'b1}}};
      w_clamp_sat = 1'b1;
    end else if (w_shifted < c_acc_min) begin
      w_clamped   = {1'b1, {(DataWidth-1){1'b0}}};
      w_clamp_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      out_preact <= '0;
      out_sat    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_len   <= w_len_next;
      r_shift <= w_shift_next;
      if (w_load_out) begin
        out_preact <= w_clamped;
        out_sat    <= w_clamp_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_accum
// Brief    : Scenario-driven, scoreboard-checked bench for neuron_accum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         cfg_len;
  logic [3:0]         cfg_shift;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_act;
  logic signed [15:0] in_wgt;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_preact;
  logic               out_sat;
  logic               busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic signed [15:0] preact;
    logic               sat;
  } exp_t;

  exp_t sb[$];

  neuron_accum #(.DataWidth(16), .LenWidth(8)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_preact(out_preact),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input longint sum, input int shift);
    exp_t   e;
    longint v;
    v = sum >>> shift;
    if (v > 32767) begin
      e.preact = 16'sh7fff; e.sat = 1'b1;
    end else if (v < -32768) begin
      e.preact = 16'sh8000; e.sat = 1'b1;
    end else begin
      e.preact = v[15:0];   e.sat = 1'b0;
    end
    return e;
  endfunction

  // Presents one term and returns at the negedge after it was accepted.
  task automatic send_term(input logic signed [15:0] a, input logic signed [15:0] w);
    int n = 0;
    in_valid = 1'b1; in_act = a; in_wgt = w;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_term_timeout in_ready=%0b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_act = 16'($urandom); in_wgt = 16'($urandom);
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); n++;
    end
    ok = out_valid;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_out_timeout out_valid=%0b expected 1", out_valid);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cfg_len = '0; cfg_shift = '0; in_act = '0; in_wgt = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (out_preact !== 16'sd0) begin errors++; $display("FAIL reset_preact got %0d expected 0", out_preact); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b expected 0", out_sat); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    exp_t e;
    cfg_len = 8'd3; cfg_shift = 4'd0;
    sb.push_back('{preact: 16'sd27, sat: 1'b0});
    send_term(16'sd2, 16'sd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_accum got %0b expected 1", busy); end
    send_term(16'sd4, -16'sd1);
    send_term(16'sd5, 16'sd5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%0b expected 1", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_out got %0b expected 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_out got %0b expected 0", in_ready); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL basic_preact got %0d expected %0d", out_preact, e.preact); end
    checks++; if (out_sat !== e.sat) begin errors++; $display("FAIL basic_sat got %0b expected %0b", out_sat, e.sat); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs out_valid=%0b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_after_hs busy=%0b expected 0", busy); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] acts [2];
    exp_t e;
    bit   ok;
    acts[0] = 16'sh7fff; acts[1] = 16'sh8000;
    sb.push_back('{preact: 16'sh7fff, sat: 1'b1});
    sb.push_back('{preact: 16'sh8000, sat: 1'b1});
    for (int k = 0; k < 2; k++) begin
      cfg_len = 8'd2; cfg_shift = 4'd0;
      send_term(acts[k], 16'sh7fff);
      send_term(acts[k], 16'sh7fff);
      wait_out(ok);
      e = sb.pop_front();
      checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL sat_preact[%0d] got %0d expected %0d", k, out_preact, e.preact); end
      checks++; if (out_sat !== e.sat) begin errors++; $display("FAIL sat_flag[%0d] got %0b expected %0b", k, out_sat, e.sat); end
      consume();
    end
  endtask

  task automatic test_floor_shift();
    exp_t e;
    cfg_len = 8'd1; cfg_shift = 4'd2;
    sb.push_back('{preact: -16'sd2, sat: 1'b0});
    send_term(-16'sd7, 16'sd1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL floor_latency out_valid=%0b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL floor_preact got %0d expected %0d", out_preact, e.preact); end
    checks++; if (out_sat !== e.sat) begin errors++; $display("FAIL floor_sat got %0b expected %0b", out_sat, e.sat); end
    consume();
  endtask

  task automatic test_backpressure();
    exp_t e;
    cfg_len = 8'd1; cfg_shift = 4'd0;
    sb.push_back('{preact: 16'sd20, sat: 1'b0});
    sb.push_back('{preact: 16'sd4, sat: 1'b0});
    send_term(16'sd5, 16'sd4);
    e = sb.pop_front();
    in_valid = 1'b1; in_act = 16'sd2; in_wgt = 16'sd2;
    for (int c = 0; c < 5; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b expected 0", c, in_ready); end
      checks++; if (out_preact !== e.preact || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %0d/%0b expected %0d/1", c, out_preact, out_valid, e.preact); end
      @(negedge clk);
    end
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle out_valid/in_ready got %0b/%0b expected 0/1", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_accept out_valid=%0b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL bp_next_preact got %0d expected %0d", out_preact, e.preact); end
    consume();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    cfg_len = 8'd4; cfg_shift = 4'd0;
    send_term(16'sd1, 16'sd2);
    send_term(16'sd3, 16'sd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle[%0d] out_valid/busy got %0b/%0b expected 0/0", c, out_valid, busy); end
      @(negedge clk);
    end
    cfg_len = 8'd1;
    sb.push_back('{preact: 16'sd9, sat: 1'b0});
    send_term(16'sd3, 16'sd3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new out_valid=%0b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL rstmid_preact got %0d expected %0d", out_preact, e.preact); end
    consume();
  endtask

  task automatic test_len_zero();
    exp_t e;
    cfg_len = 8'd0; cfg_shift = 4'd0;
    sb.push_back('{preact: 16'sd42, sat: 1'b0});
    send_term(16'sd6, 16'sd7);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %0b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL len0_preact got %0d expected %0d", out_preact, e.preact); end
    consume();
    cfg_len = 8'd2; cfg_shift = 4'd0;
    sb.push_back('{preact: 16'sd5, sat: 1'b0});
    send_term(16'sd1, 16'sd1);
    cfg_len = 8'd5; cfg_shift = 4'd3;
    send_term(16'sd2, 16'sd2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cfgchg_valid got %0b expected 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL cfgchg_preact got %0d expected %0d", out_preact, e.preact); end
    consume();
  endtask

  task automatic test_back_to_back_random();
    logic signed [15:0] ta [5];
    logic signed [15:0] tw [5];
    longint sum;
    int     len, sh;
    exp_t   e;
    bit     ok;
    for (int n = 0; n < 12; n++) begin
      len = int'($urandom_range(1, 5));
      sh  = int'($urandom_range(0, 15));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        ta[i] = 16'($urandom); tw[i] = 16'($urandom);
        sum += longint'(ta[i]) * longint'(tw[i]);
      end
      sb.push_back(model(sum, sh));
      cfg_len = 8'(len); cfg_shift = 4'(sh);
      for (int i = 0; i < len; i++) begin
        send_term(ta[i], tw[i]);
        cfg_len = 8'($urandom); cfg_shift = 4'($urandom);
        if (i < len - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_out(ok);
      e = sb.pop_front();
      checks++; if (out_preact !== e.preact) begin errors++; $display("FAIL rand_preact[%0d] got %0d expected %0d", n, out_preact, e.preact); end
      checks++; if (out_sat !== e.sat) begin errors++; $display("FAIL rand_sat[%0d] got %0b expected %0b", n, out_sat, e.sat); end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_floor_shift();
    test_backpressure();
    test_reset_mid();
    test_len_zero();
    test_back_to_back_random();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/neuron_accum.md
NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 SHALL have parameter DataWidth, default 16, the width of the activation, weight and pre-activation words (signed two's complement).
REQ-002 SHALL have parameter LenWidth, default 8, the width of the term-count configuration.
REQ-003 SHALL have an internal accumulator width AccWidth = 2*DataWidth+LenWidth, so the accumulator never wraps for any legal term count.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  the synchronous, active-high reset.
REQ-006 SHALL have port cfg_len  input  LenWidth  the number of product terms per neuron; sampled on the first accepted term.
REQ-007 SHALL have port cfg_shift  input  4  the arithmetic right-shift applied before saturation; sampled on the first accepted term.
REQ-008 SHALL have port in_valid  input  1  the upstream term valid.
REQ-009 SHALL have port in_ready  output  1  the block accepts a term this cycle.
REQ-010 SHALL have port in_act  input  DataWidth  the signed input activation.
REQ-011 SHALL have port in_wgt  input  DataWidth  the signed weight.
REQ-012 SHALL have port out_valid  output  1  the pre-activation result is valid.
REQ-013 SHALL have port out_ready  input  1  the downstream activation stage takes the result.
REQ-014 SHALL have port out_preact  output  DataWidth  the signed, saturated pre-activation.
REQ-015 SHALL have port out_sat  output  1  out_preact was clamped; valid with out_valid.
REQ-016 SHALL have port busy  output  1  high in ACCUM or OUT.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM and OUT.
REQ-018 SHALL define a term as accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-019 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in OUT.
REQ-020 On an accepted term in IDLE: SHALL load acc = in_act*in_wgt (full signed product, sign-extended, not added to the old acc), latch cfg_len and cfg_shift, and set cnt=1.
REQ-021 SHALL treat a latched cfg_len of 0 as 1.
REQ-022 On an accepted term in ACCUM: SHALL set acc = acc + in_act*in_wgt and increment cnt.
REQ-023 When the accepted term makes cnt equal the latched length (including the IDLE term when length=1): SHALL go to OUT next cycle; otherwise SHALL go from IDLE to ACCUM or stay in ACCUM.
REQ-024 SHALL have a latency of exactly 1 cycle: last term accepted at edge T, out_valid=1 from T+1.
REQ-025 On entry to OUT: SHALL register out_preact = clamp(final acc >>> shift) to [-2^(DataWidth-1), 2^(DataWidth-1)-1], using arithmetic shift with floor rounding, and set out_sat=1 iff clamping occurred.
REQ-026 SHALL hold out_preact and out_sat stable while out_valid=1 and out_ready=0.
REQ-027 On out_valid and out_ready both 1: SHALL go to IDLE next cycle with out_valid=0; the next term can be accepted from that IDLE cycle (one bubble per neuron).
REQ-028 SHALL leave acc and cnt unchanged in cycles with in_valid=0 in ACCUM; gaps of any length SHALL be allowed.
REQ-029 SHALL ignore cfg_len and cfg_shift changes outside the first-accepted-term cycle.
REQ-030 SHALL ignore in_act and in_wgt when the term is not accepted.

Reset
REQ-031 While rst=1 at a clock edge: SHALL set state=IDLE, acc=0, cnt=0, out_valid=0, out_preact=0, out_sat=0 and busy=0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-032 A reset asserted mid-ACCUM or in OUT SHALL discard the partial sum or result with no output handshake; the next accepted term starts a new neuron.

Verification
REQ-033 cfg_len=3, cfg_shift=0, terms (2,3),(4,-1),(5,5) back-to-back -> out_valid the cycle after the third acceptance, out_preact=27, out_sat=0, busy=1 through OUT.
REQ-034 DataWidth=16, cfg_len=2, cfg_shift=0, terms (32767,32767),(32767,32767) -> out_preact=32767, out_sat=1; repeat with (-32768,32767)x2 -> out_preact=-32768, out_sat=1.
REQ-035 cfg_len=1, cfg_shift=2, term (-7,1) -> out_preact=-2 (floor), out_sat=0, result 1 cycle after acceptance.
REQ-036 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_preact stable, no term consumed; out_ready=1 -> IDLE, next term accepted the cycle after.
REQ-037 cfg_len=4, two terms accepted, then rst pulsed 1 cycle -> out_valid never asserts; a new cfg_len=1 term (3,3) yields out_preact=9.
REQ-038 cfg_len=0 with a single term (6,7) -> treated as 1, out_preact=42; changing cfg_len mid-neuron has no effect on the term count.
